// File: rtl/fpg8_pkg.sv
// rtl/fpg8_pkg.sv - shared timer mode type and default bank sizes
package fpg8_pkg;

  typedef enum logic {
    TMR_ONESHOT = 1'b0,
    TMR_RELOAD  = 1'b1
  } tmr_mode_e;

  localparam int DEF_WIDTH    = 16;
  localparam int DEF_CHANNELS = 4;

endpackage

// File: rtl/timer_channel.sv
// rtl/timer_channel.sv - one down-counting timer channel with reload and sticky expiry flag
module timer_channel
  import fpg8_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tick,
  input  logic             load,
  input  logic [WIDTH-1:0] data,
  input  tmr_mode_e        mode,
  input  logic             ack,
  output logic [WIDTH-1:0] count,
  output logic             pending
);

  logic [WIDTH-1:0] reload_q;
  tmr_mode_e        mode_q;
  logic             running;
  logic             expire;

  assign expire = tick && running && (count == WIDTH'(1));

  always_ff @(posedge clk) begin
    if (!reset) begin
      count    <= '0;
      reload_q <= '0;
      mode_q   <= TMR_ONESHOT;
      running  <= 1'b0;
      pending  <= 1'b0;
    end else if (load) begin
      count    <= data;
      reload_q <= data;
      mode_q   <= mode;
      running  <= (data != '0);
      pending  <= 1'b0;
    end else begin
      if (tick && running) begin
        if (expire) begin
          if (mode_q == TMR_RELOAD) begin
            count <= reload_q;
          end else begin
            count   <= '0;
            running <= 1'b0;
          end
        end else begin
          count <= count - WIDTH'(1);
        end
      end
      // A fresh expiry outranks an acknowledge landing in the same cycle.
      if (expire) begin
        pending <= 1'b1;
      end else if (ack) begin
        pending <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/timer_bank.sv
// rtl/timer_bank.sv - bank of CHANNELS timers with readback mux and pending priority encoder
// Optional prescaler: define TIMER_PRESCALE_EN to tick once every PRESCALE cycles.
module timer_bank
  import fpg8_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int CHANNELS = DEF_CHANNELS,
`ifdef TIMER_PRESCALE_EN
  parameter int PRESCALE = 8,
`endif
  localparam int SEL_W   = $clog2(CHANNELS)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [WIDTH-1:0]    DATA,
  input  logic                timer_in,
  input  logic [SEL_W-1:0]    timer_select,
  input  logic                mode_in,
  input  logic                timeout_ack,
  output logic [WIDTH-1:0]    REG_OUT_TIMER,
  output logic [CHANNELS-1:0] pending,
  output logic                timeout,
  output logic [SEL_W-1:0]    timeout_channel
);

  logic             tick;
  logic [WIDTH-1:0] counts   [CHANNELS];
  logic [WIDTH-1:0] rd_table [2**SEL_W];

`ifdef TIMER_PRESCALE_EN
  localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  logic [PS_W-1:0] ps_cnt;

  // Free-running; loads deliberately leave its phase alone.
  always_ff @(posedge clk) begin
    if (!reset || tick) begin
      ps_cnt <= '0;
    end else begin
      ps_cnt <= ps_cnt + PS_W'(1);
    end
  end

  assign tick = (ps_cnt == PS_W'(PRESCALE - 1));
`else
  assign tick = 1'b1;
`endif

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    timer_channel #(
      .WIDTH(WIDTH)
    ) u_channel (
      .clk     (clk),
      .reset   (reset),
      .tick    (tick),
      .load    (timer_in && (timer_select == SEL_W'(i))),
      .data    (DATA),
      .mode    (tmr_mode_e'(mode_in)),
      .ack     (timeout_ack && timeout && (timeout_channel == SEL_W'(i))),
      .count   (counts[i]),
      .pending (pending[i])
    );
  end

  assign timeout = |pending;

  always_comb begin
    timeout_channel = '0;
    for (int i = CHANNELS - 1; i >= 0; i--) begin
      if (pending[i]) timeout_channel = SEL_W'(i);
    end
  end

  // Unpopulated select codes read back as zero.
  for (genvar j = 0; j < 2**SEL_W; j++) begin : g_rd
    if (j < CHANNELS) begin : g_live
      assign rd_table[j] = counts[j];
    end else begin : g_zero
      assign rd_table[j] = '0;
    end
  end

  assign REG_OUT_TIMER = rd_table[timer_select];

endmodule

// File: tb/tb_timer_bank.sv
// tb/tb_timer_bank.sv - self-checking bench for timer_bank against a tick-level reference model
module tb_timer_bank;

  localparam int W  = 16;
  localparam int CH = 6;
  localparam int SW = 3;
`ifdef TIMER_PRESCALE_EN
  localparam int TB_PS = 4;
`else
  localparam int TB_PS = 1;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic [W-1:0]  DATA;
  logic          timer_in;
  logic [SW-1:0] timer_select;
  logic          mode_in;
  logic          timeout_ack;
  logic [W-1:0]  REG_OUT_TIMER;
  logic [CH-1:0] pending;
  logic          timeout;
  logic [SW-1:0] timeout_channel;

  int checks = 0;
  int errors = 0;

  int m_rem  [CH];
  int m_per  [CH];
  bit m_auto [CH];
  bit m_pend [CH];
  int m_ps;

  timer_bank #(
    .WIDTH(W),
    .CHANNELS(CH)
`ifdef TIMER_PRESCALE_EN
    , .PRESCALE(TB_PS)
`endif
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .DATA            (DATA),
    .timer_in        (timer_in),
    .timer_select    (timer_select),
    .mode_in         (mode_in),
    .timeout_ack     (timeout_ack),
    .REG_OUT_TIMER   (REG_OUT_TIMER),
    .pending         (pending),
    .timeout         (timeout),
    .timeout_channel (timeout_channel)
  );

  always #5 clk = ~clk;

  // Reference: each channel holds "ticks remaining until expiry"; readback is that number.
  function automatic void model_edge();
    bit any;
    int tgt;
    bit tk;
    bit fired;
    if (!reset) begin
      for (int c = 0; c < CH; c++) begin
        m_rem[c] = 0; m_per[c] = 0; m_auto[c] = 0; m_pend[c] = 0;
      end
      m_ps = 0;
      return;
    end
    tk   = (m_ps == TB_PS - 1);
    m_ps = tk ? 0 : m_ps + 1;
    any = 0;
    tgt = 0;
    for (int c = CH - 1; c >= 0; c--) if (m_pend[c]) begin any = 1; tgt = c; end
    for (int c = 0; c < CH; c++) begin
      if (timer_in && int'(timer_select) == c) begin
        m_rem[c]  = int'(DATA);
        m_per[c]  = int'(DATA);
        m_auto[c] = mode_in;
        m_pend[c] = 0;
      end else begin
        fired = 0;
        if (tk && m_rem[c] > 0) begin
          m_rem[c] = m_rem[c] - 1;
          if (m_rem[c] == 0) begin
            fired = 1;
            if (m_auto[c]) m_rem[c] = m_per[c];
          end
        end
        if (fired) m_pend[c] = 1;
        else if (timeout_ack && any && tgt == c) m_pend[c] = 0;
      end
    end
  endfunction

  function automatic logic [CH-1:0] exp_pending();
    logic [CH-1:0] p;
    for (int c = 0; c < CH; c++) p[c] = m_pend[c];
    return p;
  endfunction

  function automatic logic [SW-1:0] exp_tc();
    logic [SW-1:0] t = '0;
    for (int c = CH - 1; c >= 0; c--) if (m_pend[c]) t = SW'(c);
    return t;
  endfunction

  function automatic logic [W-1:0] exp_rd();
    if (int'(timer_select) < CH) return W'(m_rem[timer_select]);
    return '0;
  endfunction

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    reset = 1'b1; timer_in = 1'b0; timeout_ack = 1'b0; mode_in = 1'b0;
    DATA = '0; timer_select = '0;
  endtask

  task automatic do_reset();
    set_idle();
    reset = 1'b0;
    step();
    reset = 1'b1;
  endtask

  task automatic load(input int ch, input int val, input bit mode);
    timer_select = SW'(ch); DATA = W'(val); mode_in = mode; timer_in = 1'b1;
    step();
    timer_in = 1'b0;
  endtask

  task automatic test_reset();
    set_idle();
    reset = 1'b0;
    step(); step();
    checks++; if (pending !== '0) begin errors++; $display("FAIL reset_pending got %h want 0", pending); end
    checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL reset_timeout got %b want 0", timeout); end
    checks++; if (REG_OUT_TIMER !== '0) begin errors++; $display("FAIL reset_count got %0d want 0", REG_OUT_TIMER); end
    checks++; if (timeout_channel !== '0) begin errors++; $display("FAIL reset_tc got %0d want 0", timeout_channel); end
    reset = 1'b1;
    load(0, 5, 1'b0);
    step(); step();
    reset = 1'b0;
    step();
    reset = 1'b1;
    timer_select = '0;
    #1;
    checks++; if (REG_OUT_TIMER !== '0) begin errors++; $display("FAIL midcount_reset_count got %0d want 0", REG_OUT_TIMER); end
    checks++; if (pending !== '0 || timeout !== 1'b0) begin errors++; $display("FAIL midcount_reset_flags got %h/%b want 0/0", pending, timeout); end
  endtask

  task automatic test_oneshot();
    int seq [4] = '{3, 2, 1, 0};
    do_reset();
    load(1, 3, 1'b0);
    for (int k = 0; k < 4; k++) begin
      if (k > 0) step();
      checks++; if (REG_OUT_TIMER !== W'(seq[k])) begin errors++; $display("FAIL oneshot_count[%0d] got %0d want %0d", k, REG_OUT_TIMER, seq[k]); end
      checks++; if (pending[1] !== (k == 3)) begin errors++; $display("FAIL oneshot_pending[%0d] got %b want %b", k, pending[1], k == 3); end
    end
    step(); step(); step();
    checks++; if (pending !== CH'(2) || REG_OUT_TIMER !== '0) begin errors++; $display("FAIL oneshot_hold got %h/%0d want 02/0", pending, REG_OUT_TIMER); end
    timeout_ack = 1'b1; step(); timeout_ack = 1'b0;
    checks++; if (pending !== '0 || timeout !== 1'b0) begin errors++; $display("FAIL oneshot_ack got %h/%b want 0/0", pending, timeout); end
  endtask

  task automatic test_reload();
    int seq [5] = '{4, 3, 2, 1, 4};
    do_reset();
    load(2, 4, 1'b1);
    for (int k = 0; k < 5; k++) begin
      if (k > 0) step();
      checks++; if (REG_OUT_TIMER !== W'(seq[k])) begin errors++; $display("FAIL reload_count[%0d] got %0d want %0d", k, REG_OUT_TIMER, seq[k]); end
      checks++; if (pending[2] !== (k == 4)) begin errors++; $display("FAIL reload_pending[%0d] got %b want %b", k, pending[2], k == 4); end
    end
    step(); step(); step();
    timeout_ack = 1'b1; step(); timeout_ack = 1'b0;
    checks++; if (pending[2] !== 1'b1 || REG_OUT_TIMER !== W'(4)) begin errors++; $display("FAIL reload_ack_vs_expiry got %b/%0d want 1/4", pending[2], REG_OUT_TIMER); end
    timeout_ack = 1'b1; step(); timeout_ack = 1'b0;
    checks++; if (pending[2] !== 1'b0) begin errors++; $display("FAIL reload_ack got %b want 0", pending[2]); end
  endtask

  task automatic test_priority();
    do_reset();
    load(3, 4, 1'b0);
    load(1, 3, 1'b0);
    step(); step(); step();
    checks++; if (pending !== CH'(6'b001010) || timeout_channel !== SW'(1)) begin errors++; $display("FAIL prio_both got %h/%0d want 0a/1", pending, timeout_channel); end
    timeout_ack = 1'b1; step();
    checks++; if (pending !== CH'(6'b001000) || timeout_channel !== SW'(3)) begin errors++; $display("FAIL prio_ack1 got %h/%0d want 08/3", pending, timeout_channel); end
    step(); timeout_ack = 1'b0;
    checks++; if (timeout !== 1'b0 || timeout_channel !== '0) begin errors++; $display("FAIL prio_ack2 got %b/%0d want 0/0", timeout, timeout_channel); end
  endtask

  task automatic test_stop();
    bit seen = 0;
    do_reset();
    load(2, 1, 1'b1);
    step();
    checks++; if (pending[2] !== 1'b1) begin errors++; $display("FAIL stop_setup got %b want 1", pending[2]); end
    load(2, 0, 1'b1);
    checks++; if (pending[2] !== 1'b0) begin errors++; $display("FAIL stop_clear got %b want 0", pending[2]); end
    for (int k = 0; k < 20; k++) begin step(); if (pending !== '0) seen = 1; end
    checks++; if (seen || REG_OUT_TIMER !== '0) begin errors++; $display("FAIL stop_idle got seen=%b count=%0d want 0/0", seen, REG_OUT_TIMER); end
    load(2, 1, 1'b1);
    step();
    timer_select = SW'(2); DATA = W'(5); mode_in = 1'b0; timer_in = 1'b1; timeout_ack = 1'b1;
    step();
    timer_in = 1'b0; timeout_ack = 1'b0;
    checks++; if (pending[2] !== 1'b0 || REG_OUT_TIMER !== W'(5)) begin errors++; $display("FAIL load_vs_ack got %b/%0d want 0/5", pending[2], REG_OUT_TIMER); end
    load(7, 9, 1'b0);
    checks++; if (REG_OUT_TIMER !== '0) begin errors++; $display("FAIL bad_select_read got %0d want 0", REG_OUT_TIMER); end
    timer_select = SW'(2);
    #1;
    checks++; if (REG_OUT_TIMER !== W'(4)) begin errors++; $display("FAIL bad_select_load got %0d want 4", REG_OUT_TIMER); end
  endtask

  task automatic test_latency();
    int n = 0;
    do_reset();
    step(); step(); step();
    load(0, 2, 1'b0);
    while (pending[0] !== 1'b1 && n < 20) begin step(); n++; end
    checks++;
`ifdef TIMER_PRESCALE_EN
    if (n < 5 || n > 8) begin errors++; $display("FAIL prescale_latency got %0d want 5..8", n); end
`else
    if (n != 2) begin errors++; $display("FAIL latency got %0d want 2", n); end
`endif
  endtask

  task automatic test_random();
    do_reset();
    for (int k = 0; k < 800; k++) begin
      reset        = ($urandom_range(0, 99) != 0);
      timer_in     = ($urandom_range(0, 5) == 0);
      timer_select = SW'($urandom_range(0, 7));
      DATA         = ($urandom_range(0, 9) == 0) ? W'($urandom) : W'($urandom_range(0, 6));
      mode_in      = $urandom_range(0, 1);
      timeout_ack  = ($urandom_range(0, 2) == 0);
      step();
      checks++; if (pending !== exp_pending()) begin errors++; $display("FAIL rand_pending@%0d got %h want %h", k, pending, exp_pending()); end
      checks++; if (timeout !== (exp_pending() != '0)) begin errors++; $display("FAIL rand_timeout@%0d got %b want %b", k, timeout, exp_pending() != '0); end
      checks++; if (timeout_channel !== exp_tc()) begin errors++; $display("FAIL rand_tc@%0d got %0d want %0d", k, timeout_channel, exp_tc()); end
      checks++; if (REG_OUT_TIMER !== exp_rd()) begin errors++; $display("FAIL rand_count@%0d got %0d want %0d", k, REG_OUT_TIMER, exp_rd()); end
    end
    set_idle();
  endtask

  initial begin
    set_idle();
    test_reset();
`ifndef TIMER_PRESCALE_EN
    test_oneshot();
    test_reload();
    test_priority();
    test_stop();
`endif
    test_latency();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/timer_bank.md
TIMER_BANK -- requirements
Module: timer_bank

Interface
REQ-001 SHALL have parameter WIDTH, default 16, counter and bus width in bits.
REQ-002 SHALL have parameter CHANNELS, default 4, number of independent timer channels (2..16).
REQ-003 SHALL derive localparam SEL_W = clog2(CHANNELS).
REQ-004 SHALL have port clk  input  1  rising-edge clock (the CPU one-shot clock).
REQ-005 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-006 SHALL have port DATA  input  WIDTH  load value from bus.
REQ-007 SHALL have port timer_in  input  1  load strobe for the selected channel.
REQ-008 SHALL have port timer_select  input  SEL_W  channel addressed by load and readback.
REQ-009 SHALL have port mode_in  input  1  0 = one-shot, 1 = auto-reload, captured on load.
REQ-010 SHALL have port timeout_ack  input  1  clears the pending flag of timeout_channel.
REQ-011 SHALL have port REG_OUT_TIMER  output  WIDTH  current count of the selected channel.
REQ-012 SHALL have port pending  output  CHANNELS  per-channel expiry flags.
REQ-013 SHALL have port timeout  output  1  OR of pending.
REQ-014 SHALL have port timeout_channel  output  SEL_W  lowest-index pending channel, 0 when none.

Function
REQ-015 SHALL, on timer_in, write DATA to count[sel] and reload[sel], capture mode[sel], clear pending[sel], and set running[sel] = (DATA != 0).
REQ-016 SHALL treat a load of 0 as stop: channel idle, count 0, no expiry ever generated.
REQ-017 SHALL decrement each running channel by 1 per tick; tick = every cycle (see REQ-027).
REQ-018 SHALL, on a tick with count == 1: set pending; one-shot: count -> 0, running cleared; auto-reload: count -> reload.
REQ-019 SHALL give load-to-pending latency of exactly N ticks for load value N; auto-reload period N ticks, with no dropped or extra cycles.
REQ-020 SHALL keep pending set until acknowledged or the channel is reloaded; a repeat expiry while pending leaves it set.
REQ-021 SHALL, on timeout_ack, clear only pending[timeout_channel]; ack with timeout low is ignored.
REQ-022 SHALL give expiry priority over ack on the same channel in the same cycle (pending stays 1).
REQ-023 SHALL give load priority over decrement, expiry and ack on the addressed channel in the same cycle.
REQ-024 SHALL ignore timer_select values >= CHANNELS for loads and return 0 on REG_OUT_TIMER.
REQ-025 SHALL drive all outputs combinationally from registered state; no bus drive.

Reset
REQ-026 SHALL, when reset is low at a clock edge, clear all count, reload, mode, running and pending bits and the prescaler, overriding every other input, including mid-count; outputs read 0 the following cycle.

Configuration
REQ-027 SHALL, with TIMER_PRESCALE_EN defined, add parameter PRESCALE (default 8) and a free-running counter 0..PRESCALE-1; tick asserts only when it equals PRESCALE-1; loads do not reset it, so latency is (N-1)*PRESCALE+1 to N*PRESCALE cycles.
REQ-028 SHALL, without TIMER_PRESCALE_EN, tick every cycle and contain no prescaler logic.

Structure
REQ-029 SHALL place the timer mode enum (TMR_ONESHOT, TMR_RELOAD) and default WIDTH/CHANNELS constants in shared package fpg8_pkg.
REQ-030 SHALL implement one channel (count, reload, mode, running, pending) as sub-module timer_channel, instantiated CHANNELS times; priority encoder and readback mux in timer_bank.

Verification
REQ-031 SHALL cover: load ch0 = 5, run 2 cycles, reset low 1 cycle -> count 0, pending 0, timeout 0.
REQ-032 SHALL cover: one-shot ch1 load 3 -> readback 3,2,1,0; pending[1]=1 after 3rd edge, holds; ack -> pending 0.
REQ-033 SHALL cover: auto-reload ch2 load 4 -> pending set every 4 cycles, readback 4,3,2,1,4; ack in same cycle as expiry -> pending stays 1.
REQ-034 SHALL cover: ch1 and ch3 expire same cycle -> timeout_channel 1; ack -> 3; ack -> timeout 0.
REQ-035 SHALL cover: load 0 onto pending ch2 -> pending[2] cleared, no expiry over 20 cycles; load and ack same cycle on ch2 -> load wins.
REQ-036 SHALL cover: TIMER_PRESCALE_EN with PRESCALE = 4, load 2 -> expiry within 5..8 cycles; without macro, load 2 -> expiry after exactly 2 cycles.
